// File: rtl/mux_tree_cfg_chain.sv
// mux_tree_cfg_chain: NUM_IN:1 routing mux whose select code lives in a
// shadow register. The shadow is loaded from a serial configuration shift
// chain (ccff_head -> ccff_tail) only on an explicit commit. Codes at or above
// NUM_IN route the constant idle level 1. An optional output register
// pipelines the data path.
module mux_tree_cfg_chain #(
  parameter int NUM_IN  = 40,
  parameter bit REG_OUT = 1'b0,
  localparam int SEL_W  = $clog2(NUM_IN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic [NUM_IN-1:0] in,
  input  logic              ccff_head,
  input  logic              cfg_en,
  input  logic              cfg_load,
  output logic              ccff_tail,
  output logic              cfg_full,
  output logic [SEL_W-1:0]  sel,
  output logic              out
);

  localparam int CNT_W = $clog2(SEL_W + 1);

  logic [SEL_W-1:0] sr_q,  sr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_s;
  logic             mux_s;

  assign full_s    = (cnt_q == CNT_W'(SEL_W));
  assign cfg_full  = full_s;
  assign ccff_tail = sr_q[SEL_W-1];
  assign sel       = sel_q;

  // Next-state for the shift chain, shadow select and shifted-bit counter.
  // The shadow takes the pre-edge shift value, so a coincident shift and
  // commit loads the old contents while the chain still advances.
  always_comb begin
    sr_d  = sr_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    if (cfg_en) begin
      sr_d = {sr_q[SEL_W-2:0], ccff_head};
    end else begin
      sr_d = sr_q;
    end
    if (cfg_load) begin
      sel_d = sr_q;
    end else begin
      sel_d = sel_q;
    end
    // A commit always clears the counter, even if a shift happens alongside.
    if (cfg_load) begin
      cnt_d = '0;
    end else if (cfg_en && !full_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Configuration state registers; reset discards any partial configuration.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sr_q  <= '0;
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  // Routing mux: unmatched codes fall through to the idle level 1, so no
  // select value can produce an X.
  always_comb begin
    mux_s = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      mux_s = (sel_q == SEL_W'(k)) ? in[k] : mux_s;
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic out_q;

    // Pipelined data path: sample the routed input on every edge.
    always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
        out_q <= 1'b0;
      end else begin
        out_q <= mux_s;
      end
    end

    assign out = out_q;
  end else begin : g_comb_out
    assign out = mux_s;
  end

endmodule

// File: doc/mux_tree_cfg_chain.md
# mux_tree_cfg_chain

Parametrised routing multiplexer with its own configuration storage. NUM_IN data inputs are selected by a binary code held in a shadow register, which is loaded from a serial configuration shift chain. Shifting new configuration does not disturb the active selection until an explicit commit. An optional output register provides pipelined routing. The block sits in routing and connection boxes as a drop-in successor to the fixed-size SRAM-driven tap-buffered mux trees, and chains through ccff_head/ccff_tail with neighbouring configuration cells.

## Interface
Parameters:
- NUM_IN, 40: number of data inputs; legal range 2..256.
- REG_OUT, 0: 0 = combinational data path; 1 = registered output.
- SEL_W, derived: clog2(NUM_IN+1); 6 when NUM_IN=40. Not overridable.

Ports:
- prog_clk  input  1  single clock for configuration and the output register.
- pReset  input  1  asynchronous, active-high reset.
- in  input  NUM_IN  data inputs, bit 0 = input 0.
- ccff_head  input  1  serial configuration data in.
- cfg_en  input  1  shift enable for the configuration chain.
- cfg_load  input  1  commit the shift register into the shadow select register.
- ccff_tail  output  1  serial configuration data out; equals shift register MSB.
- cfg_full  output  1  high once SEL_W bits have been shifted since the last commit or reset.
- sel  output  SEL_W  active select code (shadow register), for readback.
- out  output  1  multiplexer output.

## Operation
- Shift register sr[SEL_W-1:0], on a prog_clk rising edge with cfg_en=1: sr <= {sr[SEL_W-2:0], ccff_head}. The first bit shifted ends in the MSB after SEL_W shifts. ccff_tail = sr[SEL_W-1].
- Shadow register sel, on a rising edge with cfg_load=1: sel <= sr, using the pre-edge value of sr.
  - If cfg_en and cfg_load are both high in the same cycle, sel gets the old sr and sr shifts in the same edge.
- Bit counter bit_cnt, width clog2(SEL_W+1):
  - increments on each edge with cfg_en=1 and saturates at SEL_W;
  - clears on cfg_load. If cfg_load and cfg_en coincide, the clear wins and bit_cnt = 0.
  - cfg_full = (bit_cnt == SEL_W).
  - cfg_load is never gated by cfg_full. A partial commit is legal and loads whatever sr holds.
- Selection:
  - sel = k with k < NUM_IN drives in[k];
  - any code k ≥ NUM_IN drives constant 1, which is the idle level of unused tracks;
  - there are no X outputs for any code.
- REG_OUT=0: out is combinational from in and sel.
- REG_OUT=1: out_q <= mux(in, sel) on every rising edge, with no enable; out = out_q.

## Timing
- Reset values (asynchronous, while pReset=1): sr=0, sel=0, bit_cnt=0, ccff_tail=0, cfg_full=0, out_q=0.
  - REG_OUT=0: out = in[0] during reset.
  - REG_OUT=1: out = 0 during reset.
- Reset asserted mid-shift or on a commit edge: all state clears immediately, and the partial configuration is discarded.
- First edge after pReset deasserts: normal operation. No synchronizer is included in this block; deassertion timing is the integrator's concern.
- Configuration latency: SEL_W edges with cfg_en, then 1 edge with cfg_load. The new sel is visible after that edge.
  - REG_OUT=0: out follows the new sel in the same cycle.
  - REG_OUT=1: out follows one edge later.
- Data latency: REG_OUT=0 is 0 cycles. REG_OUT=1 is exactly 1 cycle, with in sampled at the rising edge.
- ccff_tail changes only on shift edges. A chain of M blocks needs M×SEL_W shift edges.
- The shadow register must not change except on cfg_load or reset. sel and out are stable throughout shifting.

## Test plan
- Reset: assert pReset mid-simulation with sel=5 → sel=0, cfg_full=0, ccff_tail=0 immediately. With REG_OUT=0, out tracks in[0]; with REG_OUT=1, out=0.
- Full configuration, NUM_IN=40: shift 6'b100111 MSB-first, then pulse cfg_load → sel=39 and out=in[39]. Toggling in[39] is reflected in out, after 1 cycle when REG_OUT=1.
- Out-of-range code: load 40, then 63 → out=1 for all in patterns.
- Shift isolation: with sel=3 committed, shift 6 new bits without cfg_load → out still equals in[3]; cfg_full rises after the 6th edge; ccff_tail emits the previous sr MSB-first.
- Simultaneous cfg_en and cfg_load: sr=6'd12, ccff_head=1, both high for one edge → sel=12, sr=6'd25, bit_cnt=0, cfg_full=0.
- Chain of two instances, NUM_IN=10 (SEL_W=4): shift 8 bits 0011_0101 then commit both → first instance sel=5, second instance sel=3; the outputs select in[5] and in[3] respectively.
